// File: rtl/tm_spi_pkg.sv
// Shared definitions for the Turing-machine serial-memory protocol: opcodes,
// bus widths and the responder state encoding.
package tm_spi_pkg;

  localparam int SPI_ADDR_W = 16;
  localparam int SPI_DATA_W = 8;

  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_READ  = 8'h03;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_RDATA,
    ST_WDATA,
    ST_IGNORE
  } resp_state_e;

endpackage

// File: rtl/tm_spi_sync.sv
// Two-flop synchronizer for one asynchronous SPI pin, plus an edge register
// that yields single-cycle rise/fall pulses on the synchronized level.
module tm_spi_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  // [0] may go metastable, [1] is the synchronized level, [2] its previous value.
  logic [2:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[1:0], async_in};
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= {3{RST_VAL}};
    else        sync_q <= sync_d;
  end

  assign level = sync_q[1];
  assign rise  = sync_q[1] & ~sync_q[2];
  assign fall  = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/tm_spi_mem_responder.sv
// SPI mode-0 slave that decodes READ/WRITE frames (cmd, 16-bit addr, data
// bytes) and drives a simple synchronous memory port with address auto-increment.
module tm_spi_mem_responder
  import tm_spi_pkg::*;
#(
  parameter int ADDR_W = SPI_ADDR_W,
  parameter int DATA_W = SPI_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_sck,
  input  logic              spi_cs,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_wr_en,
  output logic [DATA_W-1:0] mem_wdata
);

  localparam int CNT_W = $clog2(ADDR_W);

  logic sck_level_unused, sck_rise, sck_fall;
  logic cs_s, cs_rise, cs_fall;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  tm_spi_sync #(.RST_VAL(1'b0)) u_sync_sck (
    .clk(clk), .rst_n(rst_n), .async_in(spi_sck),
    .level(sck_level_unused), .rise(sck_rise), .fall(sck_fall)
  );

  // CS idles high, so its synchronizer resets high to avoid a phantom frame start.
  tm_spi_sync #(.RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .async_in(spi_cs),
    .level(cs_s), .rise(cs_rise), .fall(cs_fall)
  );

  tm_spi_sync #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .async_in(spi_mosi),
    .level(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  resp_state_e       state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] rx_q, rx_d, rx_next;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              is_read_q, is_read_d;
  logic              miso_q, miso_d;
  logic              rd_en_q, rd_en_d;
  logic              rd_valid_q;
  logic              wr_en_q, wr_en_d;

  assign rx_next = {rx_q[DATA_W-2:0], mosi_s};

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    is_read_d = is_read_q;
    miso_d    = miso_q;
    rd_en_d   = 1'b0;
    wr_en_d   = 1'b0;

    // The memory sampled the address on the strobe edge, so advance right after it.
    if (rd_en_q || wr_en_q) addr_d = addr_q + 1'b1;
    if (rd_valid_q)         tx_d   = mem_rdata;

    if (cs_rise) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      rx_d      = '0;
      miso_d    = 1'b0;
    end else if (state_q == ST_IDLE) begin
      if (cs_fall) begin
        state_d   = ST_CMD;
        bit_cnt_d = '0;
      end
    end else if (sck_rise) begin
      bit_cnt_d = bit_cnt_q + 1'b1;
      unique case (state_q)
        ST_CMD: begin
          rx_d = rx_next;
          if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
            bit_cnt_d = '0;
            if (rx_next == CMD_READ) begin
              is_read_d = 1'b1;
              state_d   = ST_ADDR;
            end else if (rx_next == CMD_WRITE) begin
              is_read_d = 1'b0;
              state_d   = ST_ADDR;
            end else begin
              state_d = ST_IGNORE;
            end
          end
        end
        ST_ADDR: begin
          addr_d = {addr_q[ADDR_W-2:0], mosi_s};
          if (bit_cnt_q == CNT_W'(ADDR_W - 1)) begin
            bit_cnt_d = '0;
            rd_en_d   = is_read_q;
            state_d   = is_read_q ? ST_RDATA : ST_WDATA;
          end
        end
        ST_RDATA: begin
          // Prefetch the next byte as the last bit of the current one is taken.
          if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
            bit_cnt_d = '0;
            rd_en_d   = 1'b1;
          end
        end
        ST_WDATA: begin
          rx_d = rx_next;
          if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
            bit_cnt_d = '0;
            wr_en_d   = 1'b1;
            wdata_d   = rx_next;
          end
        end
        default: bit_cnt_d = bit_cnt_q;
      endcase
    end else if (sck_fall && state_q == ST_RDATA) begin
      miso_d = tx_q[DATA_W-1];
      tx_d   = {tx_q[DATA_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      rx_q       <= '0;
      tx_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      is_read_q  <= 1'b0;
      miso_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      wr_en_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      is_read_q  <= is_read_d;
      miso_q     <= miso_d;
      rd_en_q    <= rd_en_d;
      rd_valid_q <= rd_en_q;
      wr_en_q    <= wr_en_d;
    end
  end

  assign spi_miso_oe = (state_q == ST_RDATA) && !cs_s;
  assign spi_miso    = spi_miso_oe & miso_q;
  assign mem_addr    = addr_q;
  assign mem_rd_en   = rd_en_q;
  assign mem_wr_en   = wr_en_q;
  assign mem_wdata   = wdata_q;

endmodule
